reg_file_sb: RTL and testbench
==============================

# reg_file_sb

Parametrised register file with an integrated scoreboard for the pipelined datapath. It provides two combinational read ports and one rising-edge write port, an optional hardwired zero register, and optional same-cycle write-to-read bypass. A per-register busy bit tracks registers with an outstanding write so that the issue stage can stall on a RAW hazard. It sits between decode (reads, reservations) and write-back (writes).

## Interface
- DATA_W, 32, register data width
- ADDR_W, 5, address width; depth = 2**ADDR_W
- ZERO_REG, 1, 1: register 0 reads 0, ignores writes and is never busy; 0: register 0 is ordinary
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rs_addr  in  ADDR_W  read port A address
- rt_addr  in  ADDR_W  read port B address
- rs_data  out  DATA_W  read port A data (combinational)
- rt_data  out  DATA_W  read port B data (combinational)
- rd_addr  in  ADDR_W  write address
- rd_data  in  DATA_W  write data
- reg_write  in  1  write enable
- rsv_valid  in  1  reserve (mark busy) request from issue
- rsv_addr  in  ADDR_W  register to reserve
- rs_busy  out  1  register at rs_addr has an outstanding write
- rt_busy  out  1  register at rt_addr has an outstanding write
- hazard  out  1  rs_busy | rt_busy
- busy_cnt  out  ADDR_W+1  number of busy registers

## Operation
- Storage: 2**ADDR_W x DATA_W flops plus a busy vector of 2**ADDR_W bits.
- Write: at the rising edge with reg_write=1, R[rd_addr] <= rd_data and busy[rd_addr] <= 0. With ZERO_REG=1 and rd_addr=0, the write is dropped.
- Reserve: at the rising edge with rsv_valid=1, busy[rsv_addr] <= 1. With ZERO_REG=1 and rsv_addr=0, the reserve is ignored.
- Simultaneous write and reserve to the same address: the data is written and busy ends at 1 (the reserve wins; a new writer is in flight).
- A write to a non-busy register is legal; busy stays 0.
- Reserving an already-busy register is legal; it stays busy and busy_cnt is unchanged.
- Read: rs_data = R[rs_addr], rt_data = R[rt_addr]. An address of 0 returns 0 when ZERO_REG=1.
- rs_busy = busy[rs_addr] and rt_busy = busy[rt_addr], subject to the bypass rule below.
- busy_cnt always equals the population count of the registered busy vector. It is updated on the same edge as the vector.

## Timing
- Read latency: 0 cycles (combinational from address and state).
- Write-to-read latency: 1 edge without bypass; 0 with bypass.
- Reserve-to-busy latency: visible the cycle after the rsv_valid edge.
- Reset (rst_n low, asynchronous): all registers and busy bits are 0.
  - reg_write and rsv_valid are ignored and bypass is suppressed.
  - rs_data=0, rt_data=0, rs_busy=0, rt_busy=0, hazard=0, busy_cnt=0.
- Reset asserted mid-operation discards pending reservations immediately; there is no recovery state.
- Deassertion takes effect at the first rising edge with rst_n high.

## Configuration
- RF_BYPASS_EN defined: when reg_write=1 and rd_addr equals a read address (and that address is not a ZERO_REG-forced 0):
  - that port returns rd_data in the same cycle;
  - its busy output is forced 0 unless rsv_valid=1 with rsv_addr equal to the same address, in which case busy stays at its stored value.
- RF_BYPASS_EN undefined: reads return stored contents only. rs_busy/rt_busy stay 1 in the write cycle and drop the cycle after.

## Test plan
- Reset, then read all 32 addresses -> every rs_data/rt_data = 0, busy_cnt=0, hazard=0.
- Write R5=0xDEADBEEF, next cycle rs_addr=5, rt_addr=5 -> both ports read 0xDEADBEEF. With ZERO_REG=1, write R0=0x1234 -> R0 reads 0.
- Reserve R7, then R9 -> busy_cnt 1 then 2. rs_addr=7 gives rs_busy=1 and hazard=1. Write R7=0x55 -> busy_cnt=1 next cycle.
- Same-cycle write and reserve of R3 (busy) with 0xA5 -> R3=0xA5, busy[3]=1, busy_cnt unchanged.
- R4 busy, reg_write R4=0x77 with rs_addr=4 in the same cycle:
  - RF_BYPASS_EN defined -> rs_data=0x77, rs_busy=0;
  - RF_BYPASS_EN undefined -> old value, rs_busy=1.
- Reserve R2 and R6, then pulse rst_n low mid-cycle -> busy_cnt=0 and all data 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/reg_file_sb.sv
// Register file (2R/1W) with per-register busy scoreboard; optional bypass via `RF_BYPASS_EN.
// Latency: reads and busy flags are combinational; writes and reservations land on the rising edge.
// Backpressure: none; the issue stage stalls on the hazard output.
module reg_file_sb #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              reg_write,
    input  logic              rsv_valid,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              rs_busy,
    output logic              rt_busy,
    output logic              hazard,
    output logic [ADDR_W:0]   busy_cnt
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;
    logic              wr_en;
    logic              rsv_en;

    function automatic logic [ADDR_W:0] popcount(input logic [DEPTH-1:0] v);
        logic [ADDR_W:0] c;
        c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            c = c + {{ADDR_W{1'b0}}, v[i]};
        end
        return c;
    endfunction

    assign wr_en  = reg_write && !((ZERO_REG != 0) && (rd_addr == '0));
    assign rsv_en = rsv_valid && !((ZERO_REG != 0) && (rsv_addr == '0));

    // Reserve is applied after the write clear so a new in-flight writer keeps the register busy.
    always_comb begin
        busy_nxt = busy;
        if (wr_en) begin
            busy_nxt[rd_addr] = 1'b0;
        end
        if (rsv_en) begin
            busy_nxt[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            if (wr_en) begin
                regs[rd_addr] <= rd_data;
            end
            busy     <= busy_nxt;
            busy_cnt <= popcount(busy_nxt);
        end
    end

    always_comb begin
        rs_data = regs[rs_addr];
        rs_busy = busy[rs_addr];
        if ((ZERO_REG != 0) && (rs_addr == '0)) begin
            rs_data = '0;
            rs_busy = 1'b0;
        end
`ifdef RF_BYPASS_EN
        else if (rst_n && reg_write && (rd_addr == rs_addr)) begin
            rs_data = rd_data;
            if (!(rsv_valid && (rsv_addr == rs_addr))) begin
                rs_busy = 1'b0;
            end
        end
`endif
    end

    always_comb begin
        rt_data = regs[rt_addr];
        rt_busy = busy[rt_addr];
        if ((ZERO_REG != 0) && (rt_addr == '0)) begin
            rt_data = '0;
            rt_busy = 1'b0;
        end
`ifdef RF_BYPASS_EN
        else if (rst_n && reg_write && (rd_addr == rt_addr)) begin
            rt_data = rd_data;
            if (!(rsv_valid && (rsv_addr == rt_addr))) begin
                rt_busy = 1'b0;
            end
        end
`endif
    end

    assign hazard = rs_busy | rt_busy;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed scoreboard bench for reg_file_sb (ZERO_REG=1); bypass expectations follow RF_BYPASS_EN.
module tb_reg_file_sb;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  rs_addr = '0, rt_addr = '0, rd_addr = '0, rsv_addr = '0;
    logic [31:0] rd_data = '0;
    logic        reg_write = 1'b0, rsv_valid = 1'b0;
    logic [31:0] rs_data, rt_data;
    logic        rs_busy, rt_busy, hazard;
    logic [5:0]  busy_cnt;

    reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data), .rt_data(rt_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .reg_write(reg_write),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
        .rs_busy(rs_busy), .rt_busy(rt_busy), .hazard(hazard), .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] rs_d;
        logic [31:0] rt_d;
        logic        rs_b;
        logic        rt_b;
        logic        hz;
        logic [5:0]  cnt;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Monitor: outputs are stable half a cycle after inputs change.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_chk++;
            if (rs_data === e.rs_d && rt_data === e.rt_d && rs_busy === e.rs_b &&
                rt_busy === e.rt_b && hazard === e.hz && busy_cnt === e.cnt) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got rs=%h rt=%h rs_busy=%b rt_busy=%b hazard=%b cnt=%0d, want rs=%h rt=%h rs_busy=%b rt_busy=%b hazard=%b cnt=%0d",
                         e.name, rs_data, rt_data, rs_busy, rt_busy, hazard, busy_cnt,
                         e.rs_d, e.rt_d, e.rs_b, e.rt_b, e.hz, e.cnt);
            end
        end
    end

    task automatic push(input string nm, input logic [31:0] ers, input logic [31:0] ert,
                        input logic ersb, input logic ertb, input logic [5:0] ecnt);
        exp_t e;
        e.name = nm; e.rs_d = ers; e.rt_d = ert;
        e.rs_b = ersb; e.rt_b = ertb; e.hz = ersb | ertb; e.cnt = ecnt;
        sb.push_back(e);
    endtask

    task automatic step(input string nm, input logic [4:0] rs, input logic [4:0] rt,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic rv, input logic [4:0] ra,
                        input logic [31:0] ers, input logic [31:0] ert,
                        input logic ersb, input logic ertb, input logic [5:0] ecnt);
        @(posedge clk); #1;
        rs_addr = rs; rt_addr = rt;
        reg_write = we; rd_addr = wa; rd_data = wd;
        rsv_valid = rv; rsv_addr = ra;
        push(nm, ers, ert, ersb, ertb, ecnt);
    endtask

    initial begin
        @(posedge clk); #1;
        rs_addr = 5'd5; rt_addr = 5'd7;
        push("in_reset", 32'h0, 32'h0, 1'b0, 1'b0, 6'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int a = 0; a < 32; a++) begin
            step("read_after_reset", 5'(a), 5'(31 - a), 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                 32'h0, 32'h0, 1'b0, 1'b0, 6'd0);
        end

`ifdef RF_BYPASS_EN
        step("wr_r5", 5'd5, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 6'd0);
`else
        step("wr_r5", 5'd5, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 6'd0);
`endif
        step("rd_r5", 5'd5, 5'd5, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 6'd0);
        step("wr_r0", 5'd0, 5'd5, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 6'd0);
        step("rd_r0", 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 6'd0);

        step("rsv_r7", 5'd7, 5'd9, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h0, 32'h0, 1'b0, 1'b0, 6'd0);
        step("rsv_r9", 5'd7, 5'd9, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h0, 32'h0, 1'b1, 1'b0, 6'd1);
        step("busy_7_9", 5'd7, 5'd9, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 1'b1, 6'd2);
`ifdef RF_BYPASS_EN
        step("wr_r7", 5'd7, 5'd9, 1'b1, 5'd7, 32'h55, 1'b0, 5'd0, 32'h55, 32'h0, 1'b0, 1'b1, 6'd2);
`else
        step("wr_r7", 5'd7, 5'd9, 1'b1, 5'd7, 32'h55, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 1'b1, 6'd2);
`endif
        step("after_wr_r7", 5'd7, 5'd9, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h55, 32'h0, 1'b0, 1'b1, 6'd1);

        step("rsv_r3", 5'd3, 5'd9, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h0, 32'h0, 1'b0, 1'b1, 6'd1);
`ifdef RF_BYPASS_EN
        step("wr_rsv_r3", 5'd3, 5'd3, 1'b1, 5'd3, 32'hA5, 1'b1, 5'd3, 32'hA5, 32'hA5, 1'b1, 1'b1, 6'd2);
`else
        step("wr_rsv_r3", 5'd3, 5'd3, 1'b1, 5'd3, 32'hA5, 1'b1, 5'd3, 32'h0, 32'h0, 1'b1, 1'b1, 6'd2);
`endif
        step("after_wr_rsv_r3", 5'd3, 5'd9, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'hA5, 32'h0, 1'b1, 1'b1, 6'd2);

        step("rsv_r0", 5'd0, 5'd9, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1, 6'd2);
        step("after_rsv_r0", 5'd0, 5'd3, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'hA5, 1'b0, 1'b1, 6'd2);

        step("rsv_r4", 5'd4, 5'd3, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h0, 32'hA5, 1'b0, 1'b1, 6'd2);
`ifdef RF_BYPASS_EN
        step("wr_r4_bypass", 5'd4, 5'd9, 1'b1, 5'd4, 32'h77, 1'b0, 5'd0, 32'h77, 32'h0, 1'b0, 1'b1, 6'd3);
`else
        step("wr_r4_nobypass", 5'd4, 5'd9, 1'b1, 5'd4, 32'h77, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 1'b1, 6'd3);
`endif
        step("after_wr_r4", 5'd4, 5'd9, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h77, 32'h0, 1'b0, 1'b1, 6'd2);

        step("wr_r10_idle", 5'd3, 5'd7, 1'b1, 5'd10, 32'h1010, 1'b0, 5'd0, 32'hA5, 32'h55, 1'b1, 1'b0, 6'd2);
        step("rd_r10", 5'd10, 5'd4, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h1010, 32'h77, 1'b0, 1'b0, 6'd2);

        step("rsv_r2", 5'd2, 5'd6, 1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 32'h0, 32'h0, 1'b0, 1'b0, 6'd2);
        step("rsv_r6", 5'd2, 5'd6, 1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h0, 32'h0, 1'b1, 1'b0, 6'd3);
        step("busy_2_6", 5'd3, 5'd6, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'hA5, 32'h0, 1'b1, 1'b1, 6'd4);

        // Reset drops between edges; outputs must clear before any clock edge.
        @(posedge clk); #1;
        rs_addr = 5'd3; rt_addr = 5'd7;
        reg_write = 1'b1; rd_addr = 5'd3; rd_data = 32'hFFFF_FFFF;
        rsv_valid = 1'b1; rsv_addr = 5'd8;
        #2 rst_n = 1'b0;
        push("mid_cycle_reset", 32'h0, 32'h0, 1'b0, 1'b0, 6'd0);
        step("held_reset", 5'd3, 5'd7, 1'b1, 5'd3, 32'hFFFF_FFFF, 1'b1, 5'd3, 32'h0, 32'h0, 1'b0, 1'b0, 6'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        reg_write = 1'b0; rsv_valid = 1'b0;
        push("after_reset_release", 32'h0, 32'h0, 1'b0, 1'b0, 6'd0);
        step("post_reset_r2_r6", 5'd2, 5'd6, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 6'd0);

        repeat (3) @(posedge clk);
        if (sb.size() != 0) begin
            n_chk++;
            $display("FAIL drain: %0d expectations unchecked, want 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
